// File: rtl/write_buffer.sv
// Posted-store write buffer with coalescing, load forwarding and one outstanding memory transaction.
// Latency: a store is buffered on acceptance; a load hit responds the next cycle; a load miss responds the cycle after mem_ack.
// Backpressure: req_ready drops for a non-coalescing store when the buffer is full, and for any load while a read is pending.
module write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic                     wb_empty,
    output logic [$clog2(DEPTH):0]   wb_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

    state_t          r_state;
    logic [29:0]     r_ent_addr [DEPTH];
    logic [31:0]     r_ent_data [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;
    logic            r_rd_pend;
    logic [29:0]     r_rd_addr;

    logic            w_coal_hit;
    logic [AW-1:0]   w_coal_idx;
    logic            w_ld_hit;
    logic [31:0]     w_ld_data;
    logic            w_acc;
    logic            w_push;
    logic            w_coal;
    logic            w_ld;
    logic            w_pop;
    logic [31:0]     w_head_data;
    logic            w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^req_addr[1:0];

    // Scan oldest to youngest so the last match seen is the youngest; the head is excluded from coalescing while it is in flight.
    always_comb begin
        w_coal_hit = 1'b0;
        w_coal_idx = r_head;
        w_ld_hit   = 1'b0;
        w_ld_data  = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < r_count &&
                r_ent_addr[r_head + AW'(i)] == req_addr[31:2]) begin
                w_ld_hit  = 1'b1;
                w_ld_data = r_ent_data[r_head + AW'(i)];
                if (!(i == 0 && r_state == DRAIN)) begin
                    w_coal_hit = 1'b1;
                    w_coal_idx = r_head + AW'(i);
                end
            end
        end
    end

    // Request acceptance and the resulting buffer operations.
    always_comb begin
        if (req_we) begin
            req_ready = (r_count < (AW+1)'(DEPTH)) | w_coal_hit;
        end else begin
            req_ready = ~r_rd_pend;
        end
        w_acc  = req_valid & req_ready;
        w_push = w_acc & req_we & ~w_coal_hit;
        w_coal = w_acc & req_we & w_coal_hit;
        w_ld   = w_acc & ~req_we;
        w_pop  = (r_state == DRAIN) & mem_ack;
        // A store coalescing into the head in the same cycle the head is launched must reach memory.
        if (w_coal && w_coal_idx == r_head) begin
            w_head_data = req_wdata;
        end else begin
            w_head_data = r_ent_data[r_head];
        end
    end

    // Entry storage: occupancy is tracked by the pointers, so the payload itself needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ent_addr[r_tail] <= req_addr[31:2];
            r_ent_data[r_tail] <= req_wdata;
        end else if (w_coal) begin
            r_ent_data[w_coal_idx] <= req_wdata;
        end
    end

    // FIFO pointers and occupancy; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Memory-side FSM with registered transaction outputs, plus load response and pending-read tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_rd_pend <= 1'b0;
            r_rd_addr <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            if (w_ld) begin
                if (w_ld_hit) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= w_ld_data;
                end else begin
                    r_rd_pend <= 1'b1;
                    r_rd_addr <= req_addr[31:2];
                end
            end
            case (r_state)
                IDLE: begin
                    if (r_rd_pend) begin
                        r_state   <= READ;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {r_rd_addr, 2'b00};
                        mem_wdata <= 32'h0;
                    end else if (r_count != '0) begin
                        r_state   <= DRAIN;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {r_ent_addr[r_head], 2'b00};
                        mem_wdata <= w_head_data;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        r_state <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        r_state   <= IDLE;
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= mem_rdata;
                        r_rd_pend <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign wb_count = r_count;
    assign wb_empty = (r_count == '0) && (r_state == IDLE) && !r_rd_pend;

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of buffered store entries (power of two, >= 2).
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-004 The block SHALL have ports req_valid / req_we  input  1 / 1  cache-side request strobe / 1=store, 0=load.
REQ-005 The block SHALL have ports req_addr / req_wdata  input  32 / 32  byte address (bits [1:0] ignored) / store data.
REQ-006 The block SHALL have port req_ready  output  1  request accepted this cycle when req_valid & req_ready.
REQ-007 The block SHALL have ports rsp_valid / rsp_rdata  output  1 / 32  one-cycle load-response pulse / load data.
REQ-008 The block SHALL have ports mem_req / mem_we / mem_addr / mem_wdata  output  1/1/32/32  memory-side transaction.
REQ-009 The block SHALL have ports mem_ack / mem_rdata  input  1 / 32  memory completion pulse / load data valid with mem_ack.
REQ-010 The block SHALL have ports wb_empty / wb_count  output  1 / clog2(DEPTH)+1  drained indicator / occupied entries.

Function
REQ-011 Entries SHALL form a FIFO (head = oldest), each holding word address [31:2] and 32-bit data.
REQ-012 Address match SHALL compare bits [31:2] only.
REQ-013 Store, youngest matching entry not in flight: data SHALL overwrite that entry (coalesce), count unchanged, accepted even when full.
REQ-014 Store, no eligible match: new entry SHALL be pushed at tail; req_ready=0 when count==DEPTH.
REQ-015 Entry currently in flight to memory SHALL never be coalesced into; a matching store allocates a new entry.
REQ-016 Load hit (any entry matches, including in-flight head): rsp_valid SHALL pulse the next cycle with youngest matching data; no memory access.
REQ-017 Load miss: address SHALL be latched as pending read; at most one pending read; req_ready=0 for loads while one is pending.
REQ-018 req_ready SHALL be combinational: store -> (count<DEPTH) | coalesce-eligible; load -> ~read_pending.
REQ-019 FSM states SHALL be IDLE, DRAIN, READ; one memory transaction outstanding at most.
REQ-020 IDLE: pending read -> READ (priority); else count>0 -> DRAIN with head; else stay IDLE.
REQ-021 mem_req SHALL be registered, asserted throughout DRAIN/READ, with mem_we/mem_addr/mem_wdata stable until mem_ack.
REQ-022 DRAIN + mem_ack: head popped, mem_req deasserted, return to IDLE (next transaction starts no earlier than the following cycle).
REQ-023 READ + mem_ack: rsp_rdata<=mem_rdata, rsp_valid pulses next cycle, read_pending cleared, return to IDLE.
REQ-024 Push and pop in the same cycle SHALL both take effect (count unchanged); push into full buffer only after pop has registered.
REQ-025 mem_ack outside DRAIN/READ SHALL be ignored.
REQ-026 wb_empty SHALL be 1 iff count==0 and state==IDLE and no pending read.
REQ-027 Head/tail pointers SHALL wrap modulo DEPTH; count SHALL distinguish full from empty.

Reset
REQ-028 While reset is low: count=0, pointers=0, state=IDLE, read_pending=0; buffered stores discarded.
REQ-029 Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, wb_empty=1, wb_count=0.
REQ-030 Reset asserted mid-transaction SHALL drop mem_req asynchronously; a later mem_ack SHALL be ignored.

Verification
REQ-031 Stores 0x10=0xA, 0x14=0xB, mem_ack after 3 cycles each -> mem writes in order [0x10]=0xA, [0x14]=0xB, then wb_empty=1.
REQ-032 DEPTH=4, mem_ack held low, 5 distinct stores -> 4 accepted, req_ready=0 on 5th; store to 0x08 (buffered, not head) still accepted, count stays 4.
REQ-033 Store 0x20=0x11 then load 0x20 with memory stalled -> rsp_valid next cycle, rsp_rdata=0x11, no mem_req with mem_we=0.
REQ-034 Head 0x30=0x1 in flight, store 0x30=0x2 -> new entry; memory receives [0x30]=0x1 then [0x30]=0x2; load 0x30 returns 0x2.
REQ-035 Two stores buffered, load miss 0x40 (mem_rdata=0x55) -> READ issued before remaining drain, rsp_rdata=0x55, then drain resumes.
REQ-036 Reset low during DRAIN with 3 entries -> mem_req=0 immediately, wb_count=0, wb_empty=1; no further memory writes.
